// File: rtl/pipeline_hazard_scoreboard_pkg.sv
// Shared types for the hazard scoreboard: controller states, in-flight entry record, select-width helper.
// Entry fields are sized for the largest supported configuration so the struct needs no parameters.
package pipeline_pkg;

  localparam int SB_RD_W  = 8;
  localparam int SB_LAT_W = 8;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } hz_state_e;

  typedef struct packed {
    logic                valid;
    logic                wen;
    logic [SB_RD_W-1:0]  rd;
    logic [SB_LAT_W-1:0] lat;
  } sb_entry_t;

  function automatic int sel_width(input int stages);
    return (stages <= 2) ? 1 : $clog2(stages);
  endfunction

endpackage

// File: rtl/pipeline_hazard_scoreboard_src_match.sv
// Youngest-producer lookup for one source operand: stall, forward select, or WB bypass.
// PIPELINE_HAZARD_RF_BYPASS_EN turns a last-entry match into a decode-side bypass instead of a stall.
module hazard_src_match
  import pipeline_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int REG_AW = 5,
  parameter int SEL_W  = 2
) (
  input  sb_entry_t [STAGES-1:0] entries_i,
  input  logic [REG_AW-1:0]      src_i,
  input  logic                   used_i,
  output logic                   stall_i,
  output logic [SEL_W-1:0]       sel_i,
  output logic                   bypass_i
);

  logic [SB_RD_W-1:0] src_ext;
  assign src_ext = SB_RD_W'(src_i);

  // Walk oldest to youngest so the youngest match overwrites any older one.
  always_comb begin
    stall_i  = 1'b0;
    sel_i    = '0;
    bypass_i = 1'b0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (used_i && entries_i[k].valid && entries_i[k].wen &&
          (src_ext != '0) && (entries_i[k].rd == src_ext)) begin
        stall_i  = 1'b0;
        sel_i    = '0;
        bypass_i = 1'b0;
        if (k == STAGES - 1) begin
`ifdef PIPELINE_HAZARD_RF_BYPASS_EN
          bypass_i = 1'b1;
`else
          stall_i  = 1'b1;
`endif
        end else if ((k + 1) < int'(entries_i[k].lat)) begin
          stall_i = 1'b1;
        end else begin
          sel_i = SEL_W'(k + 1);
        end
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_scoreboard.sv
// Hazard/forwarding scoreboard beside decode plus ecall drain-then-halt controller.
// Optional WB-to-decode bypass via PIPELINE_HAZARD_RF_BYPASS_EN (default: stall one cycle instead).
module pipeline_hazard_scoreboard
  import pipeline_pkg::*;
#(
  parameter  int STAGES  = 3,
  parameter  int NUM_SRC = 2,
  parameter  int REG_AW  = 5,
  localparam int SEL_W   = sel_width(STAGES),
  localparam int LAT_W   = sel_width(STAGES)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      id_valid,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic                      id_wen,
  input  logic [LAT_W-1:0]          id_lat,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs,
  input  logic [NUM_SRC-1:0]        id_rs_used,
  input  logic                      id_halt,
  input  logic                      flush,
  output logic                      stall,
  output logic [NUM_SRC*SEL_W-1:0]  ex_fwd_sel,
  output logic [NUM_SRC-1:0]        id_rf_bypass,
  output logic                      ex_valid,
  output logic                      busy,
  output logic                      halted
);

  sb_entry_t [STAGES-1:0]     entries_q, entries_d;
  logic [NUM_SRC*SEL_W-1:0]   fwd_q, fwd_d;
  hz_state_e                  state_q;
  logic [NUM_SRC-1:0]         src_stall;
  logic [NUM_SRC*SEL_W-1:0]   src_sel;
  logic [LAT_W-1:0]           lat_c;
  logic                       accept;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    hazard_src_match #(
      .STAGES (STAGES),
      .REG_AW (REG_AW),
      .SEL_W  (SEL_W)
    ) u_match (
      .entries_i (entries_q),
      .src_i     (id_rs[i*REG_AW +: REG_AW]),
      .used_i    (id_rs_used[i]),
      .stall_i   (src_stall[i]),
      .sel_i     (src_sel[i*SEL_W +: SEL_W]),
      .bypass_i  (id_rf_bypass[i])
    );
  end

  assign stall  = (|src_stall) || (state_q != ST_RUN);
  // Flush wins over everything: a flushed halt is never accepted.
  assign accept = id_valid && !stall && !flush;

  always_comb begin
    lat_c = id_lat;
    if (id_lat == '0) begin
      lat_c = LAT_W'(1);
    end else if (int'(id_lat) > STAGES - 1) begin
      lat_c = LAT_W'(STAGES - 1);
    end
  end

  always_comb begin
    entries_d               = '0;
    entries_d[STAGES-1:1]   = entries_q[STAGES-2:0];
    entries_d[0]            = '0;
    fwd_d                   = '0;
    if (accept) begin
      entries_d[0].valid = 1'b1;
      entries_d[0].wen   = id_wen && !id_halt;
      entries_d[0].rd    = SB_RD_W'(id_rd);
      entries_d[0].lat   = SB_LAT_W'(lat_c);
      fwd_d              = src_sel;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entries_q <= '0;
      fwd_q     <= '0;
      state_q   <= ST_RUN;
    end else begin
      entries_q <= entries_d;
      fwd_q     <= fwd_d;
      case (state_q)
        ST_RUN:   if (accept && id_halt) state_q <= ST_DRAIN;
        ST_DRAIN: if (!busy) state_q <= ST_HALTED;
        default:  state_q <= ST_HALTED;
      endcase
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      busy = busy | entries_q[k].valid;
    end
  end

  assign ex_fwd_sel = fwd_q;
  assign ex_valid   = entries_q[0].valid;
  assign halted     = (state_q == ST_HALTED);

endmodule

// File: tb/tb_pipeline_hazard_scoreboard.sv
// Directed-vector bench for pipeline_hazard_scoreboard (STAGES=3, NUM_SRC=2, REG_AW=5).
module tb_pipeline_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rd;
  logic       id_wen;
  logic [1:0] id_lat;
  logic [9:0] id_rs;
  logic [1:0] id_rs_used;
  logic       id_halt;
  logic       flush;
  logic       stall;
  logic [3:0] ex_fwd_sel;
  logic [1:0] id_rf_bypass;
  logic       ex_valid;
  logic       busy;
  logic       halted;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipeline_hazard_scoreboard #(
    .STAGES  (3),
    .NUM_SRC (2),
    .REG_AW  (5)
  ) dut (
    .clk          (clk),
    .reset        (rst_n),
    .id_valid     (id_valid),
    .id_rd        (id_rd),
    .id_wen       (id_wen),
    .id_lat       (id_lat),
    .id_rs        (id_rs),
    .id_rs_used   (id_rs_used),
    .id_halt      (id_halt),
    .flush        (flush),
    .stall        (stall),
    .ex_fwd_sel   (ex_fwd_sel),
    .id_rf_bypass (id_rf_bypass),
    .ex_valid     (ex_valid),
    .busy         (busy),
    .halted       (halted)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic wen, input logic [1:0] lat,
                       input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] used,
                       input logic halt, input logic fl);
    id_valid   = v;
    id_rd      = rd;
    id_wen     = wen;
    id_lat     = lat;
    id_rs      = {rs1, rs0};
    id_rs_used = used;
    id_halt    = halt;
    flush      = fl;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 2'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pipe();
    idle();
    repeat (3) tick();
    chk("clear_busy", 32'(busy), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    chk("rst_stall", 32'(stall), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_exv", 32'(ex_valid), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_sel", 32'(ex_fwd_sel), 0);
    #12 rst_n = 1'b1;
    tick();

    // ALU use: add x5 then sub reads x5
    drive(1'b1, 5'd5, 1'b1, 2'd1, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd9, 1'b1, 2'd1, 5'd5, 5'd0, 2'b01, 1'b0, 1'b0);
    chk("alu_stall", 32'(stall), 0);
    tick();
    chk("alu_sel", 32'(ex_fwd_sel), 32'h1);
    chk("alu_exv", 32'(ex_valid), 1);
    clear_pipe();

    // Load use: lw x6 (lat 2) then add reads x6 and x0
    drive(1'b1, 5'd6, 1'b1, 2'd2, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd10, 1'b1, 2'd1, 5'd6, 5'd0, 2'b11, 1'b0, 1'b0);
    chk("lu_stall", 32'(stall), 1);
    tick();
    chk("lu_bubble_exv", 32'(ex_valid), 0);
    chk("lu_bubble_sel", 32'(ex_fwd_sel), 0);
    chk("lu_stall2", 32'(stall), 0);
    tick();
    chk("lu_sel", 32'(ex_fwd_sel), 32'h2);
    chk("lu_exv", 32'(ex_valid), 1);
    clear_pipe();

    // Distance 3: producer x8 sits in the last entry when src1 reads it
    drive(1'b1, 5'd8, 1'b1, 2'd1, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    tick();
    drive(1'b1, 5'd11, 1'b1, 2'd1, 5'd0, 5'd8, 2'b10, 1'b0, 1'b0);
`ifdef PIPELINE_HAZARD_RF_BYPASS_EN
    chk("d3_stall", 32'(stall), 0);
    chk("d3_bypass", 32'(id_rf_bypass), 32'h2);
    tick();
    chk("d3_sel", 32'(ex_fwd_sel), 0);
    chk("d3_exv", 32'(ex_valid), 1);
`else
    chk("d3_stall", 32'(stall), 1);
    chk("d3_bypass", 32'(id_rf_bypass), 0);
    tick();
    chk("d3_stall2", 32'(stall), 0);
    chk("d3_bubble_exv", 32'(ex_valid), 0);
    tick();
    chk("d3_sel", 32'(ex_fwd_sel), 0);
    chk("d3_exv", 32'(ex_valid), 1);
`endif
    clear_pipe();

    // Two writers of x7: older lat 1, younger lat 2; younger decides
    drive(1'b1, 5'd7, 1'b1, 2'd1, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd7, 1'b1, 2'd2, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd12, 1'b1, 2'd1, 5'd7, 5'd0, 2'b01, 1'b0, 1'b0);
    chk("pri_stall", 32'(stall), 1);
    tick();
    chk("pri_stall2", 32'(stall), 0);
    chk("pri_bypass", 32'(id_rf_bypass), 0);
    tick();
    chk("pri_sel", 32'(ex_fwd_sel), 32'h2);
    clear_pipe();

    // x0 writer and x0 reader
    drive(1'b1, 5'd0, 1'b1, 2'd2, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd13, 1'b1, 2'd1, 5'd0, 5'd0, 2'b11, 1'b0, 1'b0);
    chk("x0_stall", 32'(stall), 0);
    tick();
    chk("x0_sel", 32'(ex_fwd_sel), 0);
    chk("x0_exv", 32'(ex_valid), 1);
    clear_pipe();

    // Flush with halt: halt not accepted
    drive(1'b1, 5'd0, 1'b0, 2'd1, 5'd0, 5'd0, 2'b00, 1'b1, 1'b1);
    tick();
    idle();
    chk("fl_exv", 32'(ex_valid), 0);
    chk("fl_stall", 32'(stall), 0);
    tick();
    chk("fl_halted", 32'(halted), 0);

    // Halt with all three entries busy
    for (int n = 0; n < 3; n++) begin
      drive(1'b1, 5'(20 + n), 1'b1, 2'd1, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
      tick();
    end
    chk("h_busy", 32'(busy), 1);
    drive(1'b1, 5'd0, 1'b0, 2'd1, 5'd0, 5'd0, 2'b00, 1'b1, 1'b0);
    chk("h_pre_stall", 32'(stall), 0);
    tick();
    idle();
    chk("h_e0_stall", 32'(stall), 1);
    for (int e = 1; e <= 4; e++) begin
      tick();
      chk($sformatf("h_e%0d_halted", e), 32'(halted), (e == 4) ? 1 : 0);
      chk($sformatf("h_e%0d_stall", e), 32'(stall), 1);
    end
    chk("h_busy_end", 32'(busy), 0);
    repeat (2) tick();
    chk("h_sticky", 32'(halted), 1);

    // Reset mid-drain
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    drive(1'b1, 5'd0, 1'b0, 2'd1, 5'd0, 5'd0, 2'b00, 1'b1, 1'b0);
    tick();
    idle();
    tick();
    chk("rd_busy", 32'(busy), 1);
    chk("rd_stall_pre", 32'(stall), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rd_stall", 32'(stall), 0);
    chk("rd_busy0", 32'(busy), 0);
    chk("rd_halted", 32'(halted), 0);
    chk("rd_exv", 32'(ex_valid), 0);
    chk("rd_sel", 32'(ex_fwd_sel), 0);
    #2 rst_n = 1'b1;
    tick();
    drive(1'b1, 5'd14, 1'b1, 2'd1, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
    chk("rd_run_stall", 32'(stall), 0);
    tick();
    chk("rd_run_exv", 32'(ex_valid), 1);
    idle();
    repeat (4) tick();
    chk("rd_run_halted", 32'(halted), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
